mac_seg_rx_ovf_buffer: RTL and testbench
========================================

# mac_seg_rx_ovf_buffer

Elastic buffer for the Intel segmented MAC RX stream (per-segment DATA/INFRAME/EOP_EMPTY/FCS_ERROR/ERROR/STATUS plus word VALID). It sits between the F-Tile MAC RX output, which cannot be backpressured, and the network module RX adapter, which can stall. On overflow it drops whole words and keeps the output stream well-formed: every open frame is closed with an errored terminator, and orphan frame tails are turned into idle segments. It is parametrised in segment count and depth, and counts the loss.

## Interface

Parameters:
- SEGMENTS, 4, segments per word (1..16); each segment is 64 b DATA, 1 b INFRAME, 3 b EOP_EMPTY, 1 b FCS_ERROR, 2 b ERROR, 3 b STATUS.
- FIFO_DEPTH, 16, words (power of 2, ≥4); one slot is reserved for the terminator.
- AFULL_OFFSET, 2, almost-full threshold offset.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- CLK  in  1  single clock.
- RESET_N  in  1  asynchronous, active-low reset.
- RX_DATA / RX_INFRAME / RX_EOP_EMPTY / RX_FCS_ERROR / RX_ERROR / RX_STATUS  in  SEGMENTS×(64/1/3/1/2/3)  MAC RX word.
- RX_VALID  in  1  word valid; no backpressure.
- TX_DATA / TX_INFRAME / TX_EOP_EMPTY / TX_FCS_ERROR / TX_ERROR / TX_STATUS  out  same widths  buffered word.
- TX_VALID  out  1  word available.
- TX_READY  in  1  consumer accepts.
- AFULL  out  1  count ≥ FIFO_DEPTH−1−AFULL_OFFSET.
- CNT_CLR  in  1  synchronous clear of both counters.
- OVF_WORDS  out  CNT_WIDTH  dropped words, saturating.
- OVF_FRAMES  out  CNT_WIDTH  terminators written, saturating.

## Operation

- Segment EOP: prev=1 and INFRAME=0. Segment 0 takes prev from in_prev, the INFRAME of the last segment of the previous RX_VALID word. Segment i>0 takes prev from INFRAME[i−1]. A frame always spans at least 8 segments, so no single-segment frames exist.
- State registers:
  - count: FIFO occupancy.
  - in_prev.
  - mask: discarding the tail of a broken input frame.
  - out_inframe: INFRAME of the last segment written to the FIFO.
- Accept (RX_VALID and count < FIFO_DEPTH−1):
  - Segments are walked in order with m = mask.
  - While m=1, a segment is written as idle: INFRAME, FCS_ERROR, ERROR forced to 0; DATA, EOP_EMPTY and STATUS pass through.
  - m clears after the first EOP segment. Remaining segments pass unchanged.
  - mask ← final m.
  - If mask was 1 and the word has no EOP, the word is discarded. It is not written and not counted.
  - Otherwise the word is written and out_inframe ← written INFRAME[SEGMENTS−1].
- Drop (RX_VALID and count ≥ FIFO_DEPTH−1):
  - The word is discarded and OVF_WORDS increments.
  - mask ← RX_INFRAME[SEGMENTS−1].
  - If out_inframe=1, a terminator is written into the reserved slot, OVF_FRAMES increments, and out_inframe ← 0.
  - Terminator word: segment 0 has DATA=0, INFRAME=0, EOP_EMPTY=7, FCS_ERROR=1, ERROR=2'b01, STATUS=0. All other segments are zero.
- in_prev updates on every RX_VALID word, whether accepted, discarded or dropped.
- The accept/drop decision uses the registered count only. A pop in the same cycle does not free a slot for that cycle's write.
- The reserved slot is always free when a terminator is needed, so count never exceeds FIFO_DEPTH.
- TX side is first-word-fall-through: TX_VALID = (count>0); a word pops when TX_VALID and TX_READY.
- Counters saturate at all-ones. CNT_CLR has priority over a same-cycle increment, and that event is lost.

## Timing

- Reset values while RESET_N=0:
  - All TX_* = 0, TX_VALID=0, AFULL=0, counters = 0.
  - count, mask, in_prev, out_inframe = 0.
  - A reset mid-frame leaves the next input treated as starting out of frame.
- Latency: a word written at rising edge t is presented on TX_* with TX_VALID=1 in the cycle after edge t, if the FIFO was empty. A terminator has the same latency.
- A write and a pop at the same edge leave count unchanged. Words are never reordered.
- AFULL, OVF_WORDS and OVF_FRAMES are registered and reflect the state after each edge.

## Test plan

- Reset: RESET_N=0 mid-traffic → TX_VALID=0, TX_* all 0, AFULL=0, counters 0. After release, a word with INFRAME=4'b0000 is written unmasked.
- Pass-through: SEGMENTS=4, TX_READY=1, one 12-segment frame over 3 words → identical 3 words out, each 1 cycle after input; OVF_WORDS=OVF_FRAMES=0.
- Mid-frame overflow: FIFO_DEPTH=8, TX_READY=0, continuous in-frame words → 7 accepted; the 8th is dropped and a terminator written, giving count=8, OVF_WORDS=1, OVF_FRAMES=1, AFULL=1. Raising TX_READY drains 7 words, then a terminator with segment 0 ERROR=2'b01, FCS_ERROR=1, EOP_EMPTY=7.
- Tail masking: after a drop with mask=1, send a word whose EOP is at segment 2 and SOP at segment 3 → output segments 0-2 have INFRAME=0, ERROR=0; segment 3 is unchanged. A preceding all-tail word, with no EOP, is absorbed and count is unchanged.
- Idle overflow: count=7, out_inframe=0, dropped idle word → OVF_WORDS+1, OVF_FRAMES unchanged, no terminator. With count=7 and a simultaneous pop, the word is still dropped.
- Counters: CNT_CLR=1 in the same cycle as a drop → both counters read 0 next cycle. Preset OVF_WORDS to all-ones via a CNT_WIDTH=4 build with 20 drops → OVF_WORDS holds 15.

Source files
------------

// File: rtl/mac_seg_rx_ovf_buffer.sv
// mac_seg_rx_ovf_buffer
//
// Elastic buffer between a MAC RX segmented stream that cannot be stalled and a
// consumer that can. When the FIFO fills up, incoming words are dropped whole.
// The output stream stays well-formed while this happens:
//   - any frame left open on the output is closed with an errored terminator word
//   - the orphan tail of a broken input frame is rewritten as idle segments
// The FIFO is first-word-fall-through.
//
// Ports
//   CLK, RESET_N        clock, asynchronous active-low reset
//   RX_*                MAC RX word (per-segment fields), RX_VALID qualifies it
//   TX_*                head-of-FIFO word, TX_VALID = FIFO non-empty
//   TX_READY            consumer accepts the head word
//   AFULL               registered: occupancy >= FIFO_DEPTH-1-AFULL_OFFSET
//   CNT_CLR             synchronous clear of both loss counters
//   OVF_WORDS           dropped words (saturating)
//   OVF_FRAMES          terminators inserted (saturating)
module mac_seg_rx_ovf_buffer #(
  parameter int unsigned SEGMENTS     = 4,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AFULL_OFFSET = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    CLK,
  input  logic                    RESET_N,

  input  logic [SEGMENTS*64-1:0]  RX_DATA,
  input  logic [SEGMENTS-1:0]     RX_INFRAME,
  input  logic [SEGMENTS*3-1:0]   RX_EOP_EMPTY,
  input  logic [SEGMENTS-1:0]     RX_FCS_ERROR,
  input  logic [SEGMENTS*2-1:0]   RX_ERROR,
  input  logic [SEGMENTS*3-1:0]   RX_STATUS,
  input  logic                    RX_VALID,

  output logic [SEGMENTS*64-1:0]  TX_DATA,
  output logic [SEGMENTS-1:0]     TX_INFRAME,
  output logic [SEGMENTS*3-1:0]   TX_EOP_EMPTY,
  output logic [SEGMENTS-1:0]     TX_FCS_ERROR,
  output logic [SEGMENTS*2-1:0]   TX_ERROR,
  output logic [SEGMENTS*3-1:0]   TX_STATUS,
  output logic                    TX_VALID,
  input  logic                    TX_READY,

  output logic                    AFULL,
  input  logic                    CNT_CLR,
  output logic [CNT_WIDTH-1:0]    OVF_WORDS,
  output logic [CNT_WIDTH-1:0]    OVF_FRAMES
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  // The top slot is held back so a terminator can always be written on a drop.
  localparam logic [CntW-1:0] FullLvl  = CntW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] AfullLvl = CntW'(FIFO_DEPTH - 1 - AFULL_OFFSET);

  typedef struct packed {
    logic [SEGMENTS*64-1:0] data;
    logic [SEGMENTS-1:0]    inframe;
    logic [SEGMENTS*3-1:0]  eop_empty;
    logic [SEGMENTS-1:0]    fcs_error;
    logic [SEGMENTS*2-1:0]  error;
    logic [SEGMENTS*3-1:0]  status;
  } word_t;

  word_t                 mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  mask_q, mask_d;
  logic                  in_prev_q, in_prev_d;
  logic                  out_inframe_q, out_inframe_d;
  logic                  afull_q;
  logic [CNT_WIDTH-1:0]  ovf_words_q, ovf_frames_q;

  word_t walk_word, term_word, wr_word, head;
  logic  walk_mask, walk_has_eop;
  logic  accept, drop, discard, term_wr, wr_en, pop;

  // Walk the segments in order. While masked, segments are rewritten as idle;
  // the mask lifts after the first EOP (the EOP segment itself is still idle).
  always_comb begin
    logic m;
    logic prev;
    walk_word.data      = RX_DATA;
    walk_word.inframe   = RX_INFRAME;
    walk_word.eop_empty = RX_EOP_EMPTY;
    walk_word.fcs_error = RX_FCS_ERROR;
    walk_word.error     = RX_ERROR;
    walk_word.status    = RX_STATUS;
    walk_has_eop        = 1'b0;
    m                   = mask_q;
    prev                = in_prev_q;
    for (int i = 0; i < int'(SEGMENTS); i++) begin
      if (m) begin
        walk_word.inframe[i]       = 1'b0;
        walk_word.fcs_error[i]     = 1'b0;
        walk_word.error[i*2 +: 2]  = 2'b00;
      end
      if (prev && !RX_INFRAME[i]) begin
        m            = 1'b0;
        walk_has_eop = 1'b1;
      end
      prev = RX_INFRAME[i];
    end
    walk_mask = m;
  end

  // Errored terminator: an EOP in segment 0 carrying an FCS and MAC error.
  always_comb begin
    term_word                   = '0;
    term_word.eop_empty[2:0]    = 3'd7;
    term_word.fcs_error[0]      = 1'b1;
    term_word.error[1:0]        = 2'b01;
  end

  always_comb begin
    // Decision uses the registered count; a same-cycle pop does not free a slot.
    accept  = RX_VALID && (count_q < FullLvl);
    drop    = RX_VALID && !accept;
    discard = accept && mask_q && !walk_has_eop;
    term_wr = drop && out_inframe_q;
    wr_en   = (accept && !discard) || term_wr;
    wr_word = term_wr ? term_word : walk_word;
    pop     = (count_q != '0) && TX_READY;
    count_d = count_q + CntW'(wr_en) - CntW'(pop);

    mask_d = mask_q;
    if (accept) begin
      mask_d = walk_mask;
    end else if (drop) begin
      mask_d = RX_INFRAME[SEGMENTS-1];
    end

    in_prev_d = RX_VALID ? RX_INFRAME[SEGMENTS-1] : in_prev_q;

    out_inframe_d = out_inframe_q;
    if (accept && !discard) begin
      out_inframe_d = walk_word.inframe[SEGMENTS-1];
    end else if (term_wr) begin
      out_inframe_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mask_q        <= 1'b0;
      in_prev_q     <= 1'b0;
      out_inframe_q <= 1'b0;
      afull_q       <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q       <= count_d;
      mask_q        <= mask_d;
      in_prev_q     <= in_prev_d;
      out_inframe_q <= out_inframe_d;
      afull_q       <= (count_d >= AfullLvl);
    end
  end

  // Loss counters saturate; a clear wins over a same-cycle increment.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_words_q  <= '0;
      ovf_frames_q <= '0;
    end else if (CNT_CLR) begin
      ovf_words_q  <= '0;
      ovf_frames_q <= '0;
    end else begin
      if (drop && (ovf_words_q != '1)) begin
        ovf_words_q <= ovf_words_q + CNT_WIDTH'(1);
      end
      if (term_wr && (ovf_frames_q != '1)) begin
        ovf_frames_q <= ovf_frames_q + CNT_WIDTH'(1);
      end
    end
  end

  // Head is forced to zero when empty so TX_* reads all-zero in reset.
  assign head = (count_q != '0) ? mem[rd_ptr_q] : '0;

  assign TX_DATA      = head.data;
  assign TX_INFRAME   = head.inframe;
  assign TX_EOP_EMPTY = head.eop_empty;
  assign TX_FCS_ERROR = head.fcs_error;
  assign TX_ERROR     = head.error;
  assign TX_STATUS    = head.status;
  assign TX_VALID     = (count_q != '0);
  assign AFULL        = afull_q;
  assign OVF_WORDS    = ovf_words_q;
  assign OVF_FRAMES   = ovf_frames_q;

endmodule

// File: tb/tb_mac_seg_rx_ovf_buffer.sv
// Bench for mac_seg_rx_ovf_buffer: SEGMENTS=4, FIFO_DEPTH=8, AFULL_OFFSET=2,
// CNT_WIDTH=4. A queue-based model predicts the output stream; a negedge
// process compares every cycle, and literal checks pin key scenarios.
module tb_mac_seg_rx_ovf_buffer;

  localparam int S  = 4;
  localparam int D  = 8;
  localparam int AO = 2;
  localparam int CW = 4;

  typedef struct packed {
    logic [S*64-1:0] data;
    logic [S-1:0]    inf;
    logic [S*3-1:0]  ee;
    logic [S-1:0]    fcs;
    logic [S*2-1:0]  err;
    logic [S*3-1:0]  st;
  } word_t;

  logic            CLK;
  logic            RESET_N;
  logic [S*64-1:0] RX_DATA;
  logic [S-1:0]    RX_INFRAME;
  logic [S*3-1:0]  RX_EOP_EMPTY;
  logic [S-1:0]    RX_FCS_ERROR;
  logic [S*2-1:0]  RX_ERROR;
  logic [S*3-1:0]  RX_STATUS;
  logic            RX_VALID;
  logic [S*64-1:0] TX_DATA;
  logic [S-1:0]    TX_INFRAME;
  logic [S*3-1:0]  TX_EOP_EMPTY;
  logic [S-1:0]    TX_FCS_ERROR;
  logic [S*2-1:0]  TX_ERROR;
  logic [S*3-1:0]  TX_STATUS;
  logic            TX_VALID;
  logic            TX_READY;
  logic            AFULL;
  logic            CNT_CLR;
  logic [CW-1:0]   OVF_WORDS;
  logic [CW-1:0]   OVF_FRAMES;

  mac_seg_rx_ovf_buffer #(
    .SEGMENTS    (S),
    .FIFO_DEPTH  (D),
    .AFULL_OFFSET(AO),
    .CNT_WIDTH   (CW)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .RX_DATA     (RX_DATA),
    .RX_INFRAME  (RX_INFRAME),
    .RX_EOP_EMPTY(RX_EOP_EMPTY),
    .RX_FCS_ERROR(RX_FCS_ERROR),
    .RX_ERROR    (RX_ERROR),
    .RX_STATUS   (RX_STATUS),
    .RX_VALID    (RX_VALID),
    .TX_DATA     (TX_DATA),
    .TX_INFRAME  (TX_INFRAME),
    .TX_EOP_EMPTY(TX_EOP_EMPTY),
    .TX_FCS_ERROR(TX_FCS_ERROR),
    .TX_ERROR    (TX_ERROR),
    .TX_STATUS   (TX_STATUS),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .AFULL       (AFULL),
    .CNT_CLR     (CNT_CLR),
    .OVF_WORDS   (OVF_WORDS),
    .OVF_FRAMES  (OVF_FRAMES)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic armed  = 1'b0;

  // Model state: FIFO contents as a queue plus the frame-tracking flags.
  word_t         mq[$];
  logic          m_mask, m_prev, m_oinf;
  logic [CW-1:0] m_words, m_frames;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t pat(input logic [S-1:0] inf, input int seed);
    word_t w;
    logic [15:0] s;
    s = seed[15:0];
    w.inf = inf;
    for (int i = 0; i < S; i++) begin
      w.data[i*64 +: 64] = {16'hA5A5, s, 32'(i)};
      w.ee[i*3 +: 3]     = 3'(seed + i);
      w.st[i*3 +: 3]     = 3'(seed * 3 + i + 1);
      w.fcs[i]           = 1'((seed + i) & 1);
      w.err[i*2 +: 2]    = 2'(seed + i + 1);
    end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mask   = 1'b0;
    m_prev   = 1'b0;
    m_oinf   = 1'b0;
    m_words  = '0;
    m_frames = '0;
  endtask

  // One clock edge of the model, from the inputs currently on the ports.
  task automatic model_update();
    word_t w, o;
    int    first_eop;
    logic  pop, full, inc_w, inc_f;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    pop   = TX_READY && (mq.size() > 0);
    full  = mq.size() >= D - 1;
    inc_w = 1'b0;
    inc_f = 1'b0;
    if (RX_VALID) begin
      w = '{RX_DATA, RX_INFRAME, RX_EOP_EMPTY, RX_FCS_ERROR, RX_ERROR, RX_STATUS};
      if (!full) begin
        // Locate the first frame end in the word.
        first_eop = S;
        for (int i = S - 1; i >= 0; i--) begin
          if (((i == 0) ? m_prev : w.inf[i-1]) && !w.inf[i]) first_eop = i;
        end
        o = w;
        if (m_mask) begin
          for (int i = 0; i < S; i++) begin
            if (i <= first_eop) begin
              o.inf[i] = 1'b0;
              o.fcs[i] = 1'b0;
              o.err[i*2 +: 2] = 2'b00;
            end
          end
        end
        if (m_mask && first_eop == S) begin
          // whole word is tail of a broken frame: absorbed
        end else begin
          mq.push_back(o);
          m_oinf = o.inf[S-1];
          m_mask = 1'b0;
        end
      end else begin
        inc_w  = 1'b1;
        m_mask = w.inf[S-1];
        if (m_oinf) begin
          o = '0;
          o.ee[2:0]  = 3'd7;
          o.fcs[0]   = 1'b1;
          o.err[1:0] = 2'b01;
          mq.push_back(o);
          inc_f  = 1'b1;
          m_oinf = 1'b0;
        end
      end
      m_prev = w.inf[S-1];
    end
    if (pop) mq.delete(0);
    if (CNT_CLR) begin
      m_words  = '0;
      m_frames = '0;
    end else begin
      if (inc_w && m_words != '1) m_words++;
      if (inc_f && m_frames != '1) m_frames++;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (armed) begin
      if (!RESET_N) begin
        check("rst_tx_data", TX_DATA, 0);
        check("rst_tx_fields", {TX_INFRAME, TX_EOP_EMPTY, TX_FCS_ERROR, TX_ERROR, TX_STATUS}, 0);
      end
      check("tx_valid", TX_VALID, mq.size() > 0);
      if (mq.size() > 0) begin
        check("tx_data", TX_DATA, mq[0].data);
        check("tx_inframe", TX_INFRAME, mq[0].inf);
        check("tx_eop_empty", TX_EOP_EMPTY, mq[0].ee);
        check("tx_fcs_error", TX_FCS_ERROR, mq[0].fcs);
        check("tx_error", TX_ERROR, mq[0].err);
        check("tx_status", TX_STATUS, mq[0].st);
      end
      check("afull", AFULL, mq.size() >= D - 1 - AO);
      check("ovf_words", OVF_WORDS, m_words);
      check("ovf_frames", OVF_FRAMES, m_frames);
    end
  end

  task automatic step(input logic valid, input logic [S-1:0] inf, input int seed,
                      input logic ready, input logic clr);
    word_t w;
    w            = pat(inf, seed);
    RX_VALID     = valid;
    RX_DATA      = w.data;
    RX_INFRAME   = w.inf;
    RX_EOP_EMPTY = w.ee;
    RX_FCS_ERROR = w.fcs;
    RX_ERROR     = w.err;
    RX_STATUS    = w.st;
    TX_READY     = ready;
    CNT_CLR      = clr;
    @(posedge CLK);
    model_update();
    #1;
  endtask

  initial begin
    word_t exp_w;
    model_reset();
    RESET_N = 1'b1;
    step(1'b0, 4'b0000, 0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    model_reset();
    armed = 1'b1;
    step(1'b0, 4'b0000, 0, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 0, 1'b0, 1'b0);
    RESET_N = 1'b1;

    // Pass-through: idle word, then a 12-segment frame closed in segment 0 of word 5.
    step(1'b1, 4'b0000, 1, 1'b1, 1'b0);
    exp_w = pat(4'b0000, 1);
    check("lit_first_word", TX_DATA, exp_w.data);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b1111, 10 + k, 1'b1, 1'b0);
      exp_w = pat(4'b1111, 10 + k);
      check("lit_pass_data", TX_DATA, exp_w.data);
      check("lit_pass_valid", TX_VALID, 1'b1);
    end
    step(1'b1, 4'b0000, 13, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
    check("lit_pass_ovf", {OVF_WORDS, OVF_FRAMES}, 0);

    // Mid-frame overflow: 7 accepted, the 8th dropped with a terminator.
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1111, 20 + k, 1'b0, 1'b0);
    check("lit_ovf_words", OVF_WORDS, 1);
    check("lit_ovf_frames", OVF_FRAMES, 1);
    check("lit_ovf_afull", AFULL, 1'b1);
    for (int k = 0; k < 7; k++) step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
    check("lit_term_valid", TX_VALID, 1'b1);
    check("lit_term_err", TX_ERROR[1:0], 2'b01);
    check("lit_term_fcs", TX_FCS_ERROR[0], 1'b1);
    check("lit_term_ee", TX_EOP_EMPTY[2:0], 3'd7);
    check("lit_term_inf", TX_INFRAME, 4'b0000);
    step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
    check("lit_drained", TX_VALID, 1'b0);

    // Tail masking: all-tail word absorbed, then EOP at seg 2 and SOP at seg 3.
    step(1'b1, 4'b1111, 30, 1'b0, 1'b0);
    check("lit_tail_absorbed", TX_VALID, 1'b0);
    step(1'b1, 4'b1011, 31, 1'b0, 1'b0);
    check("lit_tail_inf", TX_INFRAME, 4'b1000);
    check("lit_tail_err", TX_ERROR[5:0], 6'd0);
    check("lit_tail_fcs", TX_FCS_ERROR[2:0], 3'd0);
    exp_w = pat(4'b1011, 31);
    check("lit_tail_seg3_err", TX_ERROR[7:6], exp_w.err[7:6]);
    step(1'b1, 4'b0000, 32, 1'b0, 1'b0);

    // Idle overflow: fill to 7, drop idle word, then drop again with a pop.
    for (int k = 0; k < 5; k++) step(1'b1, 4'b0000, 40 + k, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 45, 1'b0, 1'b0);
    check("lit_idle_ovf_words", OVF_WORDS, 2);
    check("lit_idle_ovf_frames", OVF_FRAMES, 1);
    step(1'b1, 4'b0000, 46, 1'b1, 1'b0);
    check("lit_pop_drop_words", OVF_WORDS, 3);

    // Counter clear wins over a same-cycle drop; then saturation.
    step(1'b1, 4'b0000, 47, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 48, 1'b0, 1'b1);
    check("lit_clr", {OVF_WORDS, OVF_FRAMES}, 0);
    for (int k = 0; k < 20; k++) step(1'b1, 4'b0000, 50 + k, 1'b0, 1'b0);
    check("lit_sat_words", OVF_WORDS, 4'hF);
    check("lit_sat_frames", OVF_FRAMES, 0);

    // Reset mid-frame, then a fresh idle word is written unmasked.
    for (int k = 0; k < 8; k++) step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
    step(1'b1, 4'b1111, 80, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 81, 1'b0, 1'b0);
    RESET_N = 1'b0;
    model_reset();
    step(1'b1, 4'b1111, 82, 1'b0, 1'b0);
    check("lit_rst_valid", TX_VALID, 1'b0);
    check("lit_rst_afull", AFULL, 1'b0);
    check("lit_rst_cnt", {OVF_WORDS, OVF_FRAMES}, 0);
    RESET_N = 1'b1;
    step(1'b1, 4'b0000, 83, 1'b0, 1'b0);
    exp_w = pat(4'b0000, 83);
    check("lit_post_rst_valid", TX_VALID, 1'b1);
    check("lit_post_rst_data", TX_DATA, exp_w.data);
    step(1'b0, 4'b0000, 0, 1'b1, 1'b0);
    step(1'b0, 4'b0000, 0, 1'b1, 1'b0);

    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
